regfile_2w2r_sb: RTL

Parametrised successor to the pipeline register file: DATA_W x DEPTH storage with two read ports and two write ports. Adds same-cycle write-to-read bypass and a per-register busy scoreboard for the issue stage's RAW-hazard detection. Sits between decode/issue (read, set-busy) and writeback (write, clear-busy). Writes on the rising clock edge; reads are combinational.

---
 rtl/regfile_2w2r_sb.sv | 101 ++++++++++
 1 files changed

// File: rtl/regfile_2w2r_sb.sv
// Two-write / two-read register file with same-cycle write bypass and a busy scoreboard.
// Latency: writes commit at the rising edge; reads and rd_busy are combinational (zero-cycle bypass).
// Backpressure: none; every write and set is accepted the cycle it is presented.
// Optional: define RF_ZERO_REG_EN to hardwire register 0 to zero (no writes, never busy).
module regfile_2w2r_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx0,
  input  logic [IDX_W-1:0]  rd_idx1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy0,
  output logic              rd_busy1,
  input  logic              wr_en0,
  input  logic [IDX_W-1:0]  wr_idx0,
  input  logic [DATA_W-1:0] wr_data0,
  input  logic              wr_en1,
  input  logic [IDX_W-1:0]  wr_idx1,
  input  logic [DATA_W-1:0] wr_data1,
  input  logic              set_en,
  input  logic [IDX_W-1:0]  set_idx,
  output logic [DEPTH-1:0]  busy_vec
);

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DEPTH-1:0]  clr_vec;
  logic [DEPTH-1:0]  set_vec;
  logic              wr_ok0;
  logic              wr_ok1;
  logic              set_ok;

  // Qualify writes/sets: index 0 is untouchable when it is the hardwired zero register.
  always_comb begin
    wr_ok0 = wr_en0 && !(ZERO_REG && (wr_idx0 == '0));
    wr_ok1 = wr_en1 && !(ZERO_REG && (wr_idx1 == '0));
    set_ok = set_en && !(ZERO_REG && (set_idx == '0));
  end

  // Decode clears (writebacks) and sets (issue); a set overrides a same-cycle clear.
  always_comb begin
    clr_vec = '0;
    set_vec = '0;
    if (wr_ok0) clr_vec[wr_idx0] = 1'b1;
    if (wr_ok1) clr_vec[wr_idx1] = 1'b1;
    if (set_ok) set_vec[set_idx] = 1'b1;
    busy_d = set_vec | (busy_q & ~clr_vec);
  end

  // Storage: reset loads each register with its own index; port 1 is applied last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= DATA_W'(i);
    end else begin
      if (wr_ok0) regs[wr_idx0] <= wr_data0;
      if (wr_ok1) regs[wr_idx1] <= wr_data1;
    end
  end

  // Scoreboard state; reset drops all pending producers.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Read port 0: younger writeback first, then older, then storage.
  always_comb begin
    if (ZERO_REG && (rd_idx0 == '0))           rd_data0 = '0;
    else if (wr_ok1 && (wr_idx1 == rd_idx0))   rd_data0 = wr_data1;
    else if (wr_ok0 && (wr_idx0 == rd_idx0))   rd_data0 = wr_data0;
    else                                       rd_data0 = regs[rd_idx0];
  end

  // Read port 1: same priority as port 0.
  always_comb begin
    if (ZERO_REG && (rd_idx1 == '0))           rd_data1 = '0;
    else if (wr_ok1 && (wr_idx1 == rd_idx1))   rd_data1 = wr_data1;
    else if (wr_ok0 && (wr_idx0 == rd_idx1))   rd_data1 = wr_data0;
    else                                       rd_data1 = regs[rd_idx1];
  end

  // Busy lookup after same-cycle clears; a simultaneous re-set keeps the register pending.
  always_comb begin
    rd_busy0 = (busy_q[rd_idx0] & ~clr_vec[rd_idx0]) | (set_vec[rd_idx0] & clr_vec[rd_idx0]);
    rd_busy1 = (busy_q[rd_idx1] & ~clr_vec[rd_idx1]) | (set_vec[rd_idx1] & clr_vec[rd_idx1]);
  end

  assign busy_vec = busy_q;

endmodule
